// File: rtl/univ_reg_pkg.sv
// Shared constants for the universal command register: mode and FSM state encodings.
package univ_reg_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned ST_W   = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_TOG   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_JK    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SET   = 3'd4;
    localparam logic [MODE_W-1:0] MODE_CLR   = 3'd5;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'd6;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'd7;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_EXEC = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    // Shift modes are the only ones that move a bit out on ser_out.
    function automatic logic is_shift(input logic [MODE_W-1:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR);
    endfunction

endpackage

// File: rtl/univ_reg_alu.sv
// Single-step next-value function of the universal register (purely combinational).
module univ_reg_alu
    import univ_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  d,
    input  logic [WIDTH-1:0]  k,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  q_next,
    output logic              shout
);

    // One application of the selected operation; shout is the bit leaving q in shift modes.
    always_comb begin
        q_next = q;
        shout  = 1'b0;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_LOAD: q_next = d;
            MODE_TOG:  q_next = q ^ d;
            MODE_JK:   q_next = (d & ~q) | (~k & q);
            MODE_SET:  q_next = q | d;
            MODE_CLR:  q_next = q & ~d;
            MODE_SHL: begin
                q_next = {q[WIDTH-2:0], ser_in};
                shout  = q[WIDTH-1];
            end
            MODE_SHR: begin
                q_next = {ser_in, q[WIDTH-1:1]};
                shout  = q[0];
            end
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_reg_fsm.sv
// Universal command register: valid/ready command intake, repeat counter, edge detectors.
module univ_reg_fsm
    import univ_reg_pkg::*;
#(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     CNT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [MODE_W-1:0] cmd_mode,
    input  logic [WIDTH-1:0]  cmd_d,
    input  logic [WIDTH-1:0]  cmd_k,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  q,
    output logic              ser_out,
    output logic              done,
    output logic [WIDTH-1:0]  rise,
    output logic [WIDTH-1:0]  fall
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [MODE_W-1:0] mode_r;
    logic [WIDTH-1:0]  d_r;
    logic [WIDTH-1:0]  k_r;
    logic [CNT_W-1:0]  rem;
    logic [WIDTH-1:0]  q_prev;
    logic [WIDTH-1:0]  alu_q;
    logic              alu_sh;
    logic              accept;
    logic              last;

    assign accept = (state == ST_IDLE) && cmd_valid;
    assign last   = (state == ST_EXEC) && (rem == CNT_W'(1));

    univ_reg_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .mode   (mode_r),
        .q      (q),
        .d      (d_r),
        .k      (k_r),
        .ser_in (ser_in),
        .q_next (alu_q),
        .shout  (alu_sh)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, run rem applications in EXEC, one DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
            ST_EXEC: if (rem == CNT_W'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, repeat counter, register update and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            q         <= RESET_VAL;
            ser_out   <= 1'b0;
            done      <= 1'b0;
            rise      <= '0;
            fall      <= '0;
            cmd_ready <= 1'b1;
            mode_r    <= MODE_HOLD;
            d_r       <= '0;
            k_r       <= '0;
            rem       <= '0;
        end else begin
            cmd_ready <= (state_nxt == ST_IDLE);
            done      <= last;
            rise      <= q & ~q_prev;
            fall      <= ~q & q_prev;
            if (accept) begin
                mode_r <= cmd_mode;
                d_r    <= cmd_d;
                k_r    <= cmd_k;
                rem    <= (cmd_cnt == '0) ? CNT_W'(1) : cmd_cnt;
            end
            if (state == ST_EXEC) begin
                q   <= alu_q;
                rem <= rem - CNT_W'(1);
                if (is_shift(mode_r)) begin
                    ser_out <= alu_sh;
                end
            end
        end
    end

    // Previous-cycle copy of q; deliberately not reset so a reset-induced change still pulses.
    always_ff @(posedge clk) begin
        q_prev <= q;
    end

endmodule
